// File: rtl/gate_bank_checker.sv
// Self-test driver/checker for the two-input gate bank: walks a/b through all four
// vectors, compares the eight gate outputs to their truth table, reports errors and pass.
module gate_bank_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic [7:0]       gates_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       fail_mask
);

    localparam int unsigned GATE_W = 8;
    localparam int unsigned SET_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]        state,      state_nxt;
    logic [1:0]        vec,        vec_nxt;
    logic [SET_W-1:0]  settle_cnt, settle_nxt;
    logic [LOOP_W-1:0] loop_cnt,   loop_nxt;
    logic              busy_nxt,   done_nxt,  pass_nxt;
    logic [ERR_W-1:0]  err_nxt;
    logic [GATE_W-1:0] mask_nxt;
    logic [GATE_W-1:0] mism;
    logic              sample;
    logic              last_vec;

    // Ideal gate bank response, bit order {xnor,xor,nor,nand,buf,not,or,and}
    function automatic logic [GATE_W-1:0] gate_ref(input logic [1:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a, ~a, a | b, a & b};
    endfunction

    assign a_o = vec[1];
    assign b_o = vec[0];

    assign mism     = gates_i ^ gate_ref(vec);
    assign sample   = (settle_cnt == SET_W'(SETTLE_CYCLES));
    assign last_vec = (vec == 2'b11) && (loop_cnt == LOOP_W'(LOOPS - 1));

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        vec_nxt    = vec;
        settle_nxt = settle_cnt;
        loop_nxt   = loop_cnt;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        pass_nxt   = pass;
        err_nxt    = err_cnt;
        mask_nxt   = fail_mask;

        case (state)
            S_IDLE: begin
                vec_nxt  = 2'b00;
                busy_nxt = 1'b0;
                if (start) begin
                    err_nxt    = '0;
                    mask_nxt   = '0;
                    pass_nxt   = 1'b0;
                    settle_nxt = '0;
                    loop_nxt   = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (sample) begin
                    settle_nxt = '0;
                    mask_nxt   = fail_mask | mism;
                    // Saturate rather than wrap so a long faulty run never reads clean
                    if ((|mism) && (err_cnt != {ERR_W{1'b1}})) begin
                        err_nxt = err_cnt + ERR_W'(1);
                    end
                    if (last_vec) begin
                        state_nxt = S_FINISH;
                        vec_nxt   = 2'b00;
                        done_nxt  = 1'b1;
                        pass_nxt  = ((fail_mask | mism) == '0);
                    end else begin
                        vec_nxt = vec + 2'd1;
                        if (vec == 2'b11) begin
                            loop_nxt = loop_cnt + LOOP_W'(1);
                        end
                    end
                end else begin
                    settle_nxt = settle_cnt + SET_W'(1);
                end
            end
            S_FINISH: begin
                busy_nxt   = 1'b0;
                settle_nxt = '0;
                loop_nxt   = '0;
                state_nxt  = S_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                vec_nxt   = 2'b00;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            vec        <= 2'b00;
            settle_cnt <= '0;
            loop_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_mask  <= '0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            settle_cnt <= settle_nxt;
            loop_cnt   <= loop_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_cnt    <= err_nxt;
            fail_mask  <= mask_nxt;
        end
    end

endmodule

// File: tb/tb_gate_bank_checker.sv
// Scoreboard bench for gate_bank_checker: a faulty gate bank model feeds gates_i and
// each run's expected result is derived from the injected faults.
module tb_gate_bank_checker;

    localparam int SETTLE  = 1;
    localparam int LOOPS   = 2;
    localparam int ERR_W   = 3;
    localparam int WIN     = SETTLE + 1;
    localparam int LAT     = 4 * LOOPS * WIN;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    typedef struct {
        int         start;
        int         lat;
        int         err;
        logic [7:0] mask;
        logic       pass;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             a_o, b_o, busy, done, pass;
    logic [7:0]       gates_i, fail_mask;
    logic [ERR_W-1:0] err_cnt;

    logic [7:0] truth [4];
    logic [7:0] flt   [4];
    logic [7:0] fset  [4];
    exp_t       q [$];
    exp_t       cur;
    int         cyc    = 0;
    int         total  = 0;
    int         passed = 0;
    int         last_err;
    logic [7:0] last_mask;
    logic       last_pass;

    gate_bank_checker #(
        .SETTLE_CYCLES(SETTLE),
        .LOOPS        (LOOPS),
        .ERR_W        (ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_o      (a_o),
        .b_o      (b_o),
        .gates_i  (gates_i),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_mask(fail_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Gate bank: ideal truth table with per-vector injected bit flips
    always_comb gates_i = truth[{a_o, b_o}] ^ flt[{a_o, b_o}];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    endfunction

    function automatic exp_t model(input logic [7:0] f [4], input int s);
        exp_t e;
        int   nf;
        nf     = 0;
        e.mask = 8'h00;
        for (int v = 0; v < 4; v++) begin
            if (f[v] != 8'h00) nf++;
            e.mask = e.mask | f[v];
        end
        e.start = s;
        e.lat   = LAT;
        e.err   = (LOOPS * nf > ERR_MAX) ? ERR_MAX : LOOPS * nf;
        e.pass  = (e.mask == 8'h00);
        return e;
    endfunction

    // Monitor: pops an expectation on every done pulse, checks vector walk and idle holds
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            last_err  = 0;
            last_mask = 8'h00;
            last_pass = 1'b0;
            chk("reset_outputs", 32'({a_o, b_o, busy, done, pass, err_cnt, fail_mask}), 32'd0);
        end else if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                cur = q.pop_front();
                chk("latency",   32'(cyc - cur.start), 32'(cur.lat));
                chk("err_cnt",   32'(err_cnt),         32'(cur.err));
                chk("fail_mask", 32'(fail_mask),       32'(cur.mask));
                chk("pass",      32'(pass),            32'(cur.pass));
                chk("busy_fin",  32'(busy),            32'd1);
                last_err  = cur.err;
                last_mask = cur.mask;
                last_pass = cur.pass;
            end
        end else if (q.size() > 0 && cyc - q[0].start >= q[0].lat) begin
            chk("missing_done", 32'd0, 32'd1);
            void'(q.pop_front());
        end else if (q.size() > 0 && cyc >= q[0].start) begin
            chk("vector",   32'({a_o, b_o}), 32'(((cyc - q[0].start) / WIN) % 4));
            chk("busy_run", 32'(busy),       32'd1);
        end else begin
            chk("idle_busy", 32'(busy),       32'd0);
            chk("idle_vec",  32'({a_o, b_o}), 32'd0);
            chk("idle_err",  32'(err_cnt),    32'(last_err));
            chk("idle_mask", 32'(fail_mask),  32'(last_mask));
            chk("idle_pass", 32'(pass),       32'(last_pass));
        end
    end

    task automatic idle_wait();
        int n;
        n = 0;
        while (busy || q.size() != 0) begin
            @(negedge clk); #1;
            n++;
            if (n > 500) begin
                $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, q.size());
                $fatal(1, "checker never returned to idle");
            end
        end
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic run(input logic [7:0] f0, input logic [7:0] f1,
                       input logic [7:0] f2, input logic [7:0] f3);
        idle_wait();
        flt[0] = f0; flt[1] = f1; flt[2] = f2; flt[3] = f3;
        start = 1'b1;
        q.push_back(model(flt, cyc + 1));
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    function automatic logic [7:0] rand_fault();
        return ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    endfunction

    initial begin
        int s1;
        int n;
        truth[0] = 8'hB4; truth[1] = 8'h56; truth[2] = 8'h5A; truth[3] = 8'h8B;
        for (int v = 0; v < 4; v++) flt[v] = 8'h00;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        run(8'h00, 8'h00, 8'h00, 8'h00);          // clean bank
        run(8'h00, 8'h40, 8'h40, 8'h00);          // xor stuck at 0
        run(8'hFF, 8'hFF, 8'hFF, 8'hFF);          // all inverted, saturates
        run(8'h00, 8'h00, 8'h00, 8'h10);          // nand wrong at 11 only
        run(8'h01, 8'h00, 8'h00, 8'h00);          // and wrong at 00 only
        for (int i = 0; i < 12; i++) begin
            run(rand_fault(), rand_fault(), rand_fault(), rand_fault());
        end

        // Reset five cycles into a faulty run; asserted between edges
        run(8'h00, 8'h80, 8'h00, 8'h00);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        #1;
        run(8'h00, 8'h00, 8'h00, 8'h00);

        // start held high: faulty run, then a clean run begins right after FINISH
        idle_wait();
        flt[0] = 8'h00; flt[1] = 8'h22; flt[2] = 8'h00; flt[3] = 8'h04;
        for (int v = 0; v < 4; v++) fset[v] = 8'h00;
        start = 1'b1;
        s1 = cyc + 1;
        q.push_back(model(flt, s1));
        q.push_back(model(fset, s1 + LAT + 2));
        n = 0;
        while (!done) begin
            @(negedge clk); #1;
            n++;
            if (n > 500) begin
                $display("FAIL done_timeout: no done while start held");
                $fatal(1, "done never asserted");
            end
        end
        for (int v = 0; v < 4; v++) flt[v] = fset[v];
        while (cyc < s1 + LAT + 5) begin
            @(negedge clk); #1;
        end
        start = 1'b0;
        idle_wait();

        run(rand_fault(), 8'h00, rand_fault(), 8'h00);
        idle_wait();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
